prio_enc_rr: RTL and testbench

Parametrised, registered N-to-log2(N) priority encoder with selectable fixed or round-robin priority and a valid/ready output handshake. It generalises the team's combinational 8-to-3 enabled priority encoder into a sequential grant stage that can be reused wherever several requesters share one resource. Requests are sampled into a held grant, and the grant stays stable until the consumer accepts it.

---
 rtl/prio_enc_rr_pkg.sv | 18 +
 rtl/prio_enc_rr_find.sv | 31 +++
 rtl/prio_enc_rr.sv | 96 +++++++++
 tb/tb_prio_enc_rr.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_rr_pkg.sv
// Shared definitions for the round-robin / fixed priority grant stage.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Decrement with wrap-around modulo an arbitrary (not necessarily 2^n) width.
  function automatic int wrap_dec(input int value, input int width);
    if (value <= 0) return width - 1;
    return value - 1;
  endfunction

endpackage

// File: rtl/prio_enc_rr_find.sv
// Rotated priority search: scans start, start-1, ..., 0, WIDTH-1, ..., start+1
// and reports the first set request bit.
module prio_find
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] pos;

  // Walk the search order once; the first hit wins and later hits are ignored.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      pos = IDX_W'((int'(start) + WIDTH - k) % WIDTH);
      if (!found && req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered priority encoder with fixed or round-robin priority and a
// valid/ready output. A grant is held until accepted; a new grant can be
// loaded on the accepting edge for one grant per cycle throughput.
module prio_enc_rr
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             accept;
  logic             load;
  logic [IDX_W-1:0] ptr_eff;
  logic [IDX_W-1:0] find_start;
  logic [IDX_W-1:0] find_idx;
  logic             find_found;

  // Pointer as seen by this edge's search: on a round-robin accept the
  // granted index already drops to lowest priority for a back-to-back load.
  always_comb begin
    accept  = (state_q == HOLD) && out_ready;
    ptr_eff = ptr_q;
    if (accept && (mode == MODE_RR)) begin
      ptr_eff = IDX_W'(wrap_dec(int'(idx_q), WIDTH));
    end
    find_start = (mode == MODE_RR) ? ptr_eff : LAST;
  end

  prio_find #(
    .WIDTH(WIDTH)
  ) u_find (
    .req  (req),
    .start(find_start),
    .idx  (find_idx),
    .found(find_found)
  );

  // Next-state: load in IDLE, hold until ready, reload or drain on accept.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    load    = en && find_found;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          idx_d   = find_idx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ptr_d = ptr_eff;
          if (load) begin
            idx_d = find_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and grant registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= LAST;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign out_idx   = idx_q;
  assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_prio_enc_rr.sv
// Bench for prio_enc_rr: an 8-wide and a 5-wide instance run side by side
// against a behavioural model, with directed steps followed by random traffic.
module tb_prio_enc_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       out_ready;
  logic [7:0] req8;
  logic [4:0] req5;
  logic [2:0] out_idx8;
  logic [2:0] out_idx5;
  logic       out_valid8;
  logic       out_valid5;

  int total = 0;
  int bad   = 0;

  // Model state per instance: index 0 is WIDTH=8, index 1 is WIDTH=5.
  int m_valid [2];
  int m_idx   [2];
  int m_ptr   [2];

  always #5 clk = ~clk;

  prio_enc_rr #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .req      (req8),
    .out_idx  (out_idx8),
    .out_valid(out_valid8),
    .out_ready(out_ready)
  );

  prio_enc_rr #(.WIDTH(5)) dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .req      (req5),
    .out_idx  (out_idx5),
    .out_valid(out_valid5),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // First set bit walking downward from start with wrap-around; -1 if none.
  function automatic int search(input int r, input int start, input int w);
    int p;
    for (int k = 0; k < w; k++) begin
      p = (start - k + w) % w;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  // Advance the model over one clock edge, then compare both instances.
  task automatic step();
    int w;
    int r;
    int hit;
    for (int u = 0; u < 2; u++) begin
      w = (u == 0) ? 8 : 5;
      r = (u == 0) ? int'(req8) : int'(req5);
      if (!rst_n) begin
        m_valid[u] = 0;
        m_idx[u]   = 0;
        m_ptr[u]   = w - 1;
      end else if (m_valid[u] == 0) begin
        hit = search(r, mode ? m_ptr[u] : w - 1, w);
        if (en && hit >= 0) begin
          m_idx[u]   = hit;
          m_valid[u] = 1;
        end
      end else if (out_ready) begin
        if (mode) m_ptr[u] = (m_idx[u] + w - 1) % w;
        hit = search(r, mode ? m_ptr[u] : w - 1, w);
        if (en && hit >= 0) m_idx[u] = hit;
        else m_valid[u] = 0;
      end
    end
    @(posedge clk);
    #1;
    check("valid8", {31'd0, out_valid8}, m_valid[0]);
    check("idx8", {29'd0, out_idx8}, m_idx[0]);
    check("valid5", {31'd0, out_valid5}, m_valid[1]);
    check("idx5", {29'd0, out_idx5}, m_idx[1]);
    $display("t=%0t rst_n=%0b en=%0b mode=%0b rdy=%0b req8=%02h req5=%02h | v8=%0b i8=%0d v5=%0b i5=%0d",
             $time, rst_n, en, mode, out_ready, req8, req5, out_valid8, out_idx8, out_valid5, out_idx5);
  endtask

  initial begin
    int seq3 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int seq6 [4] = '{4, 0, 4, 0};

    // Reset held with everything requesting.
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; out_ready = 1'b1;
    req8 = 8'hFF; req5 = 5'h1F;
    m_valid = '{0, 0}; m_idx = '{0, 0}; m_ptr = '{7, 4};
    step();
    check("rst_valid", {31'd0, out_valid8}, 0);
    step();
    check("rst_idx", {29'd0, out_idx8}, 0);
    rst_n = 1'b1;
    step();
    check("first_valid", {31'd0, out_valid8}, 1);
    check("first_idx", {29'd0, out_idx8}, 7);

    // Fixed priority, continuous accept.
    mode = 1'b0; req8 = 8'b0010_0110; req5 = 5'b00110;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fixed_idx", {29'd0, out_idx8}, 5);
      check("fixed_valid", {31'd0, out_valid8}, 1);
    end
    req8 = 8'h00; req5 = 5'h00;
    step();
    check("fixed_drain", {31'd0, out_valid8}, 0);

    // Round-robin with all requesters active.
    mode = 1'b1; req8 = 8'hFF; req5 = 5'h1F;
    for (int i = 0; i < 9; i++) begin
      step();
      check("rr_seq", {29'd0, out_idx8}, seq3[i]);
      check("rr_valid", {31'd0, out_valid8}, 1);
    end

    // Hold under back-pressure; request changes are ignored while held.
    out_ready = 1'b0; req8 = 8'b1000_0001;
    step();
    req8 = 8'h02;
    step();
    step();
    check("hold_idx", {29'd0, out_idx8}, 7);
    out_ready = 1'b1;
    step();
    check("after_hold", {29'd0, out_idx8}, 1);
    req8 = 8'h00; req5 = 5'h00;
    step();

    // Enable gating.
    en = 1'b0; req8 = 8'h10;
    step();
    step();
    check("en_block", {31'd0, out_valid8}, 0);
    en = 1'b1;
    step();
    check("en_idx", {29'd0, out_idx8}, 4);
    en = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("en_hold", {31'd0, out_valid8}, 1);
    out_ready = 1'b1;
    step();
    check("en_noreload", {31'd0, out_valid8}, 0);

    // Non-power-of-two width, alternation and reset mid-hold.
    rst_n = 1'b0; en = 1'b1; req8 = 8'h00;
    step();
    rst_n = 1'b1; mode = 1'b1; req5 = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      step();
      check("w5_alt", {29'd0, out_idx5}, seq6[i]);
    end
    rst_n = 1'b0;
    step();
    check("w5_rst", {31'd0, out_valid5}, 0);
    rst_n = 1'b1;
    step();
    check("w5_ptr_reset", {29'd0, out_idx5}, 4);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      en        = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      req8      = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      req5      = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
      step();
      check("w5_range", {31'd0, (out_idx5 < 3'd5)}, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
